// File: rtl/scan_test_ctrl_if.sv
// scan_test_ctrl_if: tester-side handshake and scan-chain signals for scan_test_ctrl
// master: system/tester side plus the DUT chain tail (drives start, abort, vectors, scan_out)
// slave: the controller (drives scan_en, scan_in, capture, status and results)
interface scan_test_ctrl_if #(parameter int CHAIN_LEN = 2);
    logic                 start;
    logic                 abort;
    logic [CHAIN_LEN-1:0] pattern_in;
    logic [CHAIN_LEN-1:0] expected_in;
    logic                 scan_out;
    logic                 scan_en;
    logic                 scan_in;
    logic                 capture;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [CHAIN_LEN-1:0] fail_mask;
    logic [CHAIN_LEN-1:0] response;
    modport master(
        output start, abort, pattern_in, expected_in, scan_out,
        input  scan_en, scan_in, capture, busy, done, pass, fail_mask, response
    );
    modport slave(
        input  start, abort, pattern_in, expected_in, scan_out,
        output scan_en, scan_in, capture, busy, done, pass, fail_mask, response
    );
endinterface

// File: rtl/scan_test_ctrl.sv
// scan_test_ctrl: shifts a pattern into a DUT scan chain, captures, shifts the response out and compares it
// clk/rst: clock and synchronous active-high reset
// bus (slave): start/abort/pattern_in/expected_in/scan_out in; scan_en/scan_in/capture/busy/done/pass/fail_mask/response out
module scan_test_ctrl #(
    parameter int CHAIN_LEN = 2
) (
    input logic            clk,
    input logic            rst,
    scan_test_ctrl_if.slave bus
);
    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam logic [CW-1:0] LEN = CW'(CHAIN_LEN);
    typedef enum logic [1:0] {IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT} state_t;
    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CHAIN_LEN-1:0] pat_q, pat_d, exp_q, exp_d, resp_q, resp_d, mask_q, mask_d, resp_shift;
    logic                 scan_en_q, scan_en_d, scan_in_q, scan_in_d, capture_q, capture_d;
    logic                 busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pat_d      = pat_q;
        exp_d      = exp_q;
        resp_d     = resp_q;
        mask_d     = mask_q;
        scan_en_d  = scan_en_q;
        scan_in_d  = scan_in_q;
        capture_d  = capture_q;
        busy_d     = busy_q;
        pass_d     = pass_q;
        done_d     = 1'b0;
        resp_shift = (resp_q << 1) | CHAIN_LEN'(bus.scan_out);
        if (state_q == IDLE) begin
            if (bus.start) begin
                // MSB goes out on scan_in right away; the rest waits in pat_q, MSB-aligned
                pat_d     = bus.pattern_in << 1;
                exp_d     = bus.expected_in;
                scan_in_d = bus.pattern_in[CHAIN_LEN-1];
                scan_en_d = 1'b1;
                busy_d    = 1'b1;
                cnt_d     = LEN;
                pass_d    = 1'b0;
                mask_d    = '0;
                resp_d    = '0;
                state_d   = SHIFT_IN;
            end
        end else if (bus.abort) begin
            state_d   = IDLE;
            scan_en_d = 1'b0;
            scan_in_d = 1'b0;
            capture_d = 1'b0;
            busy_d    = 1'b0;
            pass_d    = 1'b0;
            mask_d    = '0;
        end else begin
            case (state_q)
                SHIFT_IN: begin
                    cnt_d = cnt_q - CW'(1);
                    pat_d = pat_q << 1;
                    if (cnt_q == CW'(1)) begin
                        state_d   = CAPTURE;
                        scan_en_d = 1'b0;
                        scan_in_d = 1'b0;
                        capture_d = 1'b1;
                    end else begin
                        scan_in_d = pat_q[CHAIN_LEN-1];
                    end
                end
                CAPTURE: begin
                    state_d   = SHIFT_OUT;
                    capture_d = 1'b0;
                    scan_en_d = 1'b1;
                    scan_in_d = 1'b0;
                    cnt_d     = LEN;
                end
                SHIFT_OUT: begin
                    resp_d = resp_shift;
                    cnt_d  = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d   = IDLE;
                        scan_en_d = 1'b0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        pass_d    = resp_shift == exp_q;
                        mask_d    = resp_shift ^ exp_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pat_q     <= '0;
            exp_q     <= '0;
            resp_q    <= '0;
            mask_q    <= '0;
            scan_en_q <= 1'b0;
            scan_in_q <= 1'b0;
            capture_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pat_q     <= pat_d;
            exp_q     <= exp_d;
            resp_q    <= resp_d;
            mask_q    <= mask_d;
            scan_en_q <= scan_en_d;
            scan_in_q <= scan_in_d;
            capture_q <= capture_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
        end
    end
    assign bus.scan_en   = scan_en_q;
    assign bus.scan_in   = scan_in_q;
    assign bus.capture   = capture_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.fail_mask = mask_q;
    assign bus.response  = resp_q;
endmodule

// File: tb/tb_scan_test_ctrl.sv
// tb_scan_test_ctrl: directed checks of scan_test_ctrl against a 2-flop scan chain model
module tb_scan_test_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int errors = 0;
    int checks = 0;
    logic ha_mode = 1'b1;
    logic a_in = 1'b1;
    logic b_in = 1'b1;
    logic [1:0] chain = 2'b00;
    scan_test_ctrl_if #(.CHAIN_LEN(2)) bus();
    scan_test_ctrl #(.CHAIN_LEN(2)) dut(.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    // chain[0] nearest scan_in, chain[1] nearest scan_out; half-adder mode captures {a_in, b_in}
    always @(posedge clk) begin
        if (bus.scan_en) chain <= {chain[0], bus.scan_in};
        else if (ha_mode) chain <= {a_in, b_in};
    end
    assign bus.scan_out = chain[1];

    task automatic do_start(input logic [1:0] p, input logic [1:0] e);
        bus.start = 1'b1;
        bus.pattern_in = p;
        bus.expected_in = e;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.scan_en, bus.scan_in, bus.capture, bus.busy, bus.done, bus.pass} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 000000", {bus.scan_en, bus.scan_in, bus.capture, bus.busy, bus.done, bus.pass});
        end
        checks++;
        if ({bus.fail_mask, bus.response} !== 4'b0) begin
            errors++;
            $display("FAIL reset_data: got %b want 0000", {bus.fail_mask, bus.response});
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_ha_pass;
        logic [4:0] en, si, cap;
        ha_mode = 1'b1;
        do_start(2'b10, 2'b11);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL pass_busy: got %b want 1", bus.busy);
        end
        for (int i = 0; i < 5; i++) begin
            en[4-i] = bus.scan_en;
            si[4-i] = bus.scan_in;
            cap[4-i] = bus.capture;
            @(posedge clk); #1;
        end
        checks++;
        if (en !== 5'b11011) begin
            errors++;
            $display("FAIL pass_scan_en_seq: got %b want 11011", en);
        end
        checks++;
        if (si !== 5'b10000) begin
            errors++;
            $display("FAIL pass_scan_in_seq: got %b want 10000", si);
        end
        checks++;
        if (cap !== 5'b00100) begin
            errors++;
            $display("FAIL pass_capture_seq: got %b want 00100", cap);
        end
        checks++;
        if ({bus.done, bus.busy, bus.scan_en} !== 3'b100) begin
            errors++;
            $display("FAIL pass_done_cycle: got done/busy/en=%b want 100", {bus.done, bus.busy, bus.scan_en});
        end
        checks++;
        if ({bus.response, bus.pass, bus.fail_mask} !== 5'b11100) begin
            errors++;
            $display("FAIL pass_result: got resp/pass/mask=%b want 11100", {bus.response, bus.pass, bus.fail_mask});
        end
        @(posedge clk); #1;
        checks++;
        if ({bus.done, bus.pass} !== 2'b01) begin
            errors++;
            $display("FAIL pass_done_pulse: got done/pass=%b want 01", {bus.done, bus.pass});
        end
    endtask

    task automatic test_ha_fail;
        int n;
        ha_mode = 1'b1;
        do_start(2'b10, 2'b01);
        wait_done(n);
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL fail_latency: got %0d want 5", n);
        end
        checks++;
        if ({bus.response, bus.pass, bus.fail_mask} !== 5'b11010) begin
            errors++;
            $display("FAIL fail_result: got resp/pass/mask=%b want 11010", {bus.response, bus.pass, bus.fail_mask});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_bit_order;
        int n;
        ha_mode = 1'b0;
        do_start(2'b01, 2'b01);
        wait_done(n);
        checks++;
        if ({bus.response, bus.pass, bus.fail_mask} !== 5'b01100 || n != 5) begin
            errors++;
            $display("FAIL bit_order: got resp/pass/mask=%b n=%0d want 01100 n=5", {bus.response, bus.pass, bus.fail_mask}, n);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_start_busy;
        int dones = 0;
        logic [4:0] res = '0;
        ha_mode = 1'b0;
        do_start(2'b10, 2'b10);
        bus.start = 1'b1;
        bus.pattern_in = 2'b01;
        bus.expected_in = 2'b01;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.done === 1'b1) begin
                dones++;
                res = {bus.response, bus.pass, bus.fail_mask};
            end
            @(posedge clk); #1;
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL busy_start_dones: got %0d want 1", dones);
        end
        checks++;
        if (res !== 5'b10100) begin
            errors++;
            $display("FAIL busy_start_result: got resp/pass/mask=%b want 10100", res);
        end
    endtask

    task automatic test_abort;
        int dones = 0;
        int n;
        ha_mode = 1'b1;
        do_start(2'b10, 2'b11);
        repeat (2) begin
            @(posedge clk); #1;
        end
        checks++;
        if (bus.capture !== 1'b1) begin
            errors++;
            $display("FAIL abort_in_capture: got capture=%b want 1", bus.capture);
        end
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        checks++;
        if ({bus.busy, bus.scan_en, bus.capture, bus.done, bus.pass, bus.fail_mask} !== 6'b0) begin
            errors++;
            $display("FAIL abort_outputs: got %b want 000000", {bus.busy, bus.scan_en, bus.capture, bus.done, bus.pass, bus.fail_mask});
        end
        for (int i = 0; i < 8; i++) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
            @(posedge clk); #1;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d active cycles want 0", dones);
        end
        bus.abort = 1'b1;
        do_start(2'b10, 2'b11);
        bus.abort = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL start_with_abort: got busy=%b want 1", bus.busy);
        end
        wait_done(n);
        checks++;
        if ({bus.response, bus.pass} !== 3'b111 || n != 5) begin
            errors++;
            $display("FAIL start_with_abort_result: got resp/pass=%b n=%0d want 111 n=5", {bus.response, bus.pass}, n);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int n;
        ha_mode = 1'b1;
        do_start(2'b10, 2'b01);
        wait_done(n);
        do_start(2'b10, 2'b11);
        checks++;
        if ({bus.busy, bus.done, bus.pass, bus.fail_mask} !== 5'b10000) begin
            errors++;
            $display("FAIL b2b_accept: got busy/done/pass/mask=%b want 10000", {bus.busy, bus.done, bus.pass, bus.fail_mask});
        end
        wait_done(n);
        checks++;
        if ({bus.response, bus.pass, bus.fail_mask} !== 5'b11100 || n != 5) begin
            errors++;
            $display("FAIL b2b_result: got resp/pass/mask=%b n=%0d want 11100 n=5", {bus.response, bus.pass, bus.fail_mask}, n);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_rst_mid;
        int n;
        ha_mode = 1'b1;
        do_start(2'b10, 2'b11);
        repeat (3) begin
            @(posedge clk); #1;
        end
        checks++;
        if ({bus.busy, bus.scan_en, bus.capture} !== 3'b110) begin
            errors++;
            $display("FAIL rst_in_shift_out: got busy/en/cap=%b want 110", {bus.busy, bus.scan_en, bus.capture});
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({bus.scan_en, bus.scan_in, bus.capture, bus.busy, bus.done, bus.pass, bus.fail_mask, bus.response} !== 10'b0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got %b want 0000000000", {bus.scan_en, bus.scan_in, bus.capture, bus.busy, bus.done, bus.pass, bus.fail_mask, bus.response});
        end
        do_start(2'b10, 2'b11);
        wait_done(n);
        checks++;
        if ({bus.response, bus.pass, bus.fail_mask} !== 5'b11100 || n != 5) begin
            errors++;
            $display("FAIL rst_mid_rerun: got resp/pass/mask=%b n=%0d want 11100 n=5", {bus.response, bus.pass, bus.fail_mask}, n);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.pattern_in = 2'b00;
        bus.expected_in = 2'b00;
        test_reset;
        test_ha_pass;
        test_ha_fail;
        test_bit_order;
        test_start_busy;
        test_abort;
        test_back_to_back;
        test_rst_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/scan_test_ctrl.md
# scan_test_ctrl

Scan-test controller that drives a DUT scan chain of length CHAIN_LEN. It is the tester end of the scan interface: it shifts a stimulus pattern in over scan_in with scan_en high, then drops scan_en for one capture cycle. It then shifts the captured response out of scan_out and compares it against an expected vector, reporting pass/fail and a per-bit mismatch mask. It sits between the test bench or system test logic and a scan-enabled block such as the scanned half adder.

## Interface
- CHAIN_LEN, 2, number of flops in the DUT scan chain; legal range ≥1.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a test; sampled only in IDLE.
- abort  in  1  terminate the current test; sampled in any busy state.
- pattern_in  in  CHAIN_LEN  stimulus vector, latched on start.
- expected_in  in  CHAIN_LEN  expected response vector, latched on start.
- scan_out  in  1  serial data from the DUT chain tail.
- scan_en  out  1  DUT shift enable.
- scan_in  out  1  serial data to the DUT chain head.
- capture  out  1  high during the capture cycle, so the system can drive DUT functional inputs.
- busy  out  1  test in progress.
- done  out  1  one-cycle pulse when a test completes normally.
- pass  out  1  1 when the response equals the expected vector; valid from done until the next accepted start.
- fail_mask  out  CHAIN_LEN  captured XOR expected; same validity as pass.
- response  out  CHAIN_LEN  captured response vector.

## Operation
- States: IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT. All outputs are registered.
- Bit order: bit CHAIN_LEN-1 corresponds to the flop nearest scan_out and bit 0 to the flop nearest scan_in. pattern_in[CHAIN_LEN-1] is shifted first.
- IDLE:
  - start=1 latches pattern_in and expected_in.
  - Clears pass, fail_mask and response.
  - Loads the shift counter.
  - Next state is SHIFT_IN.
- SHIFT_IN:
  - scan_en=1.
  - scan_in presents the next pattern bit, MSB first.
  - Lasts exactly CHAIN_LEN cycles, then goes to CAPTURE.
- CAPTURE:
  - scan_en=0, scan_in=0, capture=1.
  - Lasts exactly one cycle, then goes to SHIFT_OUT.
- SHIFT_OUT:
  - scan_en=1, scan_in=0.
  - Each edge does response <= {response[CHAIN_LEN-2:0], scan_out}.
  - Lasts CHAIN_LEN cycles.
  - On the last edge: pass <= (final response == expected), fail_mask <= final response ^ expected, done <= 1, next state IDLE.
- start while busy: ignored.
- start with abort in IDLE: abort is ignored, start is accepted.
- abort while busy: next edge goes to IDLE with scan_en=0, capture=0, busy=0. No done pulse. pass=0, fail_mask=0.
- rst: same effect as abort at any time. The latched vectors are cleared.
- The shift counter is $clog2(CHAIN_LEN+1) bits wide and never wraps. CHAIN_LEN=1 gives one shift-in cycle and one shift-out cycle.

## Timing
- Reset values: scan_en=0, scan_in=0, capture=0, busy=0, done=0, pass=0, fail_mask=0, response=0; state IDLE.
- Start accepted at edge E0:
  - After E0: busy=1, scan_en=1, scan_in=pattern[CHAIN_LEN-1].
  - Edges E1..E_N: shift-in edges; edge Ek loads pattern bit CHAIN_LEN-k into the DUT.
  - After E_N: capture=1, scan_en=0.
  - E_{N+1}: DUT capture edge.
  - Edges E_{N+2}..E_{2N+1}: sample scan_out, then shift.
  - After E_{2N+1}: done=1 and busy=0 for exactly one cycle; pass and fail_mask valid.
- Total latency from the start edge to done is 2·CHAIN_LEN+1 cycles.
- A start in the done cycle is accepted at the next edge, so back-to-back tests have no dead cycle beyond done.

## Test plan
- Chain is the 2-flop half-adder scan chain (CHAIN_LEN=2). pattern=2'b10, functional a_in=1, b_in=1 during capture, expected=2'b11.
  - Required: response=2'b11, pass=1, fail_mask=2'b00.
  - scan_en timing is high, high, low, high, high.
  - done is asserted 5 cycles after the start edge.
- Same setup with expected=2'b01.
  - Required: pass=0, fail_mask=2'b10, response=2'b11.
- DUT is a pure 2-flop shift register that holds state on capture. pattern=2'b01, expected=2'b01.
  - Required: response=2'b01 and pass=1, which proves the bit ordering.
- start asserted in SHIFT_IN with new vectors.
  - Required: ignored; the result matches the first test's vectors; exactly one done pulse.
- abort in CAPTURE.
  - Required: IDLE next cycle, scan_en=0, busy=0, no done, pass=0.
- rst asserted mid SHIFT_OUT.
  - Required: all outputs 0 at the next edge.
  - A following start runs a complete, correct test.
